// File: rtl/response_analyzer.sv
// MBIST read-side checker: two-stage compare pipeline feeding a saturating error
// counter, sticky fail/overflow flags and a first-word-fall-through fail log.
module response_analyzer #(
   parameter int DW        = 8,
   parameter int AW        = 8,
   parameter int LOG_DEPTH = 4,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sbmt_in,
   input  logic             end_in,
   input  logic             cmp_vld_in,
   input  logic [AW-1:0]    addr_in,
   input  logic [DW-1:0]    data_in,
   input  logic [DW-1:0]    ptrn_in,
   input  logic             log_rd_in,
   output logic             busy_out,
   output logic             done_out,
   output logic             fail_out,
   output logic             ovf_out,
   output logic [CNT_W-1:0] err_cnt_out,
   output logic             log_vld_out,
   output logic [AW-1:0]    log_addr_out,
   output logic [DW-1:0]    log_syn_out
);
   localparam int PW = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;
   localparam int CW = $clog2(LOG_DEPTH + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CW-1:0]    LOG_FULL = CW'(LOG_DEPTH);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN1,
      ST_DRAIN2,
      ST_DONE
   } state_t;

   state_t            state_q, state_d;
   logic              s1_vld_q, s1_vld_d;
   logic [AW-1:0]     s1_addr_q, s1_addr_d;
   logic [DW-1:0]     s1_syn_q, s1_syn_d;
   logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
   logic              fail_q, fail_d;
   logic              ovf_q, ovf_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     log_cnt_q, log_cnt_d;
   logic [AW-1:0]     log_addr_mem [LOG_DEPTH];
   logic [DW-1:0]     log_syn_mem  [LOG_DEPTH];

   logic accept, miss, full, pop, push, drop;

   // Session state: sbmt_in restarts from anywhere, DRAIN holds two cycles so
   // a word accepted alongside end_in retires before DONE.
   always_comb begin
      state_d = state_q;
      if (sbmt_in) begin
         state_d = ST_RUN;
      end else begin
         case (state_q)
            ST_RUN:    if (end_in) state_d = ST_DRAIN1;
            ST_DRAIN1: state_d = ST_DRAIN2;
            ST_DRAIN2: state_d = ST_DONE;
            default:   state_d = state_q;
         endcase
      end
   end

   always_comb begin
      accept = (state_q == ST_RUN) && cmp_vld_in && !sbmt_in;
      miss   = s1_vld_q && (s1_syn_q != '0);
      full   = (log_cnt_q == LOG_FULL);
      pop    = log_rd_in && (log_cnt_q != '0) && !sbmt_in;
      push   = miss && (!full || pop) && !sbmt_in;
      drop   = miss && full && !pop && !sbmt_in;

      s1_vld_d  = accept;
      s1_addr_d = s1_addr_q;
      s1_syn_d  = s1_syn_q;
      if (accept) begin
         s1_addr_d = addr_in;
         s1_syn_d  = data_in ^ ptrn_in;
      end

      err_cnt_d = err_cnt_q;
      if (miss && (err_cnt_q != CNT_MAX)) err_cnt_d = err_cnt_q + CNT_W'(1);
      fail_d = fail_q | miss;
      ovf_d  = ovf_q | drop;

      wr_ptr_d  = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d  = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      log_cnt_d = log_cnt_q;
      case ({push, pop})
         2'b10:   log_cnt_d = log_cnt_q + CW'(1);
         2'b01:   log_cnt_d = log_cnt_q - CW'(1);
         default: log_cnt_d = log_cnt_q;
      endcase

      if (sbmt_in) begin
         err_cnt_d = '0;
         fail_d    = 1'b0;
         ovf_d     = 1'b0;
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         log_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         s1_vld_q  <= 1'b0;
         err_cnt_q <= '0;
         fail_q    <= 1'b0;
         ovf_q     <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         log_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         s1_vld_q  <= s1_vld_d;
         err_cnt_q <= err_cnt_d;
         fail_q    <= fail_d;
         ovf_q     <= ovf_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         log_cnt_q <= log_cnt_d;
      end
   end

   // Datapath storage carries no reset; its validity is tracked by s1_vld_q
   // and log_cnt_q.
   always_ff @(posedge clk) begin
      s1_addr_q <= s1_addr_d;
      s1_syn_q  <= s1_syn_d;
      if (push) begin
         log_addr_mem[wr_ptr_q] <= s1_addr_q;
         log_syn_mem[wr_ptr_q]  <= s1_syn_q;
      end
   end

   always_comb begin
      busy_out     = (state_q == ST_RUN) || (state_q == ST_DRAIN1) ||
                     (state_q == ST_DRAIN2);
      done_out     = (state_q == ST_DONE);
      fail_out     = fail_q;
      ovf_out      = ovf_q;
      err_cnt_out  = err_cnt_q;
      log_vld_out  = (log_cnt_q != '0);
      log_addr_out = log_vld_out ? log_addr_mem[rd_ptr_q] : '0;
      log_syn_out  = log_vld_out ? log_syn_mem[rd_ptr_q]  : '0;
   end

endmodule

// File: tb/tb_response_analyzer.sv
// Randomized bench for response_analyzer; a queue-based model of the fail log
// and plain counters supply every expected value.
module tb_response_analyzer;
   localparam int DW = 8;
   localparam int AW = 8;
   localparam int LOG_DEPTH = 4;
   localparam int CNT_W = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic sbmt_in = 1'b0, end_in = 1'b0, cmp_vld_in = 1'b0, log_rd_in = 1'b0;
   logic [AW-1:0] addr_in = '0;
   logic [DW-1:0] data_in = '0, ptrn_in = '0;
   logic busy_out, done_out, fail_out, ovf_out, log_vld_out;
   logic [CNT_W-1:0] err_cnt_out;
   logic [AW-1:0] log_addr_out;
   logic [DW-1:0] log_syn_out;

   int errors = 0;
   int checks = 0;

   // Reference model of one session
   int m_cnt;
   bit m_fail, m_ovf;
   logic [AW+DW-1:0] m_q[$];

   response_analyzer #(.DW(DW), .AW(AW), .LOG_DEPTH(LOG_DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .sbmt_in(sbmt_in), .end_in(end_in),
      .cmp_vld_in(cmp_vld_in), .addr_in(addr_in), .data_in(data_in),
      .ptrn_in(ptrn_in), .log_rd_in(log_rd_in), .busy_out(busy_out),
      .done_out(done_out), .fail_out(fail_out), .ovf_out(ovf_out),
      .err_cnt_out(err_cnt_out), .log_vld_out(log_vld_out),
      .log_addr_out(log_addr_out), .log_syn_out(log_syn_out)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      m_cnt = 0;
      m_fail = 0;
      m_ovf = 0;
      m_q.delete();
   endtask

   task automatic model_word(input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [DW-1:0] p);
      logic [DW-1:0] syn;
      syn = d ^ p;
      if (syn != 0) begin
         if (m_cnt < CNT_MAX) m_cnt++;
         m_fail = 1;
         if (m_q.size() < LOG_DEPTH) m_q.push_back({a, syn});
         else m_ovf = 1;
      end
   endtask

   task automatic start_session();
      sbmt_in = 1'b1;
      tick();
      sbmt_in = 1'b0;
      model_clear();
   endtask

   task automatic send_word(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [DW-1:0] p, input bit upd);
      cmp_vld_in = 1'b1;
      addr_in = a;
      data_in = d;
      ptrn_in = p;
      tick();
      if (upd) model_word(a, d, p);
   endtask

   task automatic send_miss(input bit upd);
      logic [DW-1:0] p, s;
      p = DW'($urandom);
      s = DW'($urandom_range(1, 255));
      send_word(AW'($urandom), p ^ s, p, upd);
   endtask

   task automatic end_session();
      cmp_vld_in = 1'b0;
      end_in = 1'b1;
      tick();
      end_in = 1'b0;
      tick();
      tick();
   endtask

   task automatic check_results(input string tag);
      checks++;
      if (err_cnt_out !== m_cnt[CNT_W-1:0]) begin
         errors++;
         $display("FAIL %s_err_cnt: got %0d want %0d", tag, err_cnt_out, m_cnt);
      end
      checks++;
      if (fail_out !== m_fail) begin
         errors++;
         $display("FAIL %s_fail: got %0b want %0b", tag, fail_out, m_fail);
      end
      checks++;
      if (ovf_out !== m_ovf) begin
         errors++;
         $display("FAIL %s_ovf: got %0b want %0b", tag, ovf_out, m_ovf);
      end
   endtask

   task automatic drain_and_check(input string tag);
      logic [AW+DW-1:0] e;
      while (m_q.size() > 0) begin
         e = m_q.pop_front();
         checks++;
         if (log_vld_out !== 1'b1 || {log_addr_out, log_syn_out} !== e) begin
            errors++;
            $display("FAIL %s_log_entry: got vld=%0b %0h want vld=1 %0h", tag,
                     log_vld_out, {log_addr_out, log_syn_out}, e);
         end
         log_rd_in = 1'b1;
         tick();
         log_rd_in = 1'b0;
      end
      checks++;
      if (log_vld_out !== 1'b0) begin
         errors++;
         $display("FAIL %s_log_empty: got vld=%0b want 0", tag, log_vld_out);
      end
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if ({busy_out, done_out, fail_out, ovf_out, err_cnt_out, log_vld_out,
           log_addr_out, log_syn_out} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got busy=%0b done=%0b fail=%0b ovf=%0b cnt=%0d vld=%0b want all 0",
                  busy_out, done_out, fail_out, ovf_out, err_cnt_out, log_vld_out);
      end
      rst = 1'b1;
      tick();
      end_in = 1'b1;
      tick();
      end_in = 1'b0;
      checks++;
      if (busy_out !== 1'b0 || done_out !== 1'b0) begin
         errors++;
         $display("FAIL idle_end_ignored: got busy=%0b done=%0b want 0 0", busy_out, done_out);
      end
   endtask

   task automatic test_clean();
      logic [DW-1:0] v;
      start_session();
      checks++;
      if (busy_out !== 1'b1 || done_out !== 1'b0) begin
         errors++;
         $display("FAIL clean_run_state: got busy=%0b done=%0b want 1 0", busy_out, done_out);
      end
      for (int i = 0; i < 32; i++) begin
         v = ($urandom_range(0, 1) != 0) ? 8'h55 : 8'hAA;
         send_word(AW'(i), v, v, 1'b1);
      end
      end_session();
      checks++;
      if (done_out !== 1'b1 || busy_out !== 1'b0) begin
         errors++;
         $display("FAIL clean_done: got done=%0b busy=%0b want 1 0", done_out, busy_out);
      end
      check_results("clean");
      drain_and_check("clean");
   endtask

   task automatic test_single_miss();
      start_session();
      send_word(8'h13, 8'h5D, 8'h55, 1'b1);
      cmp_vld_in = 1'b0;
      checks++;
      if (fail_out !== 1'b0) begin
         errors++;
         $display("FAIL single_fail_early: got %0b want 0", fail_out);
      end
      tick();
      check_results("single");
      checks++;
      if (log_vld_out !== 1'b1 || log_addr_out !== 8'h13 || log_syn_out !== 8'h08) begin
         errors++;
         $display("FAIL single_log_head: got vld=%0b addr=%0h syn=%0h want 1 13 08",
                  log_vld_out, log_addr_out, log_syn_out);
      end
      end_session();
      checks++;
      if (done_out !== 1'b1) begin
         errors++;
         $display("FAIL single_done: got %0b want 1", done_out);
      end
      drain_and_check("single");
   endtask

   task automatic test_overflow();
      start_session();
      for (int i = 0; i < 6; i++) send_miss(1'b1);
      cmp_vld_in = 1'b0;
      tick();
      tick();
      check_results("ovf");
      drain_and_check("ovf");
      log_rd_in = 1'b1;
      tick();
      log_rd_in = 1'b0;
      checks++;
      if (log_vld_out !== 1'b0 || err_cnt_out !== m_cnt[CNT_W-1:0]) begin
         errors++;
         $display("FAIL ovf_pop_empty: got vld=%0b cnt=%0d want 0 %0d", log_vld_out,
                  err_cnt_out, m_cnt);
      end
   endtask

   task automatic test_push_pop_full();
      logic [DW-1:0] p, s;
      logic [AW-1:0] a;
      start_session();
      for (int i = 0; i < LOG_DEPTH; i++) send_miss(1'b1);
      cmp_vld_in = 1'b0;
      tick();
      tick();
      for (int i = 0; i < 6; i++) begin
         p = DW'($urandom);
         s = DW'($urandom_range(1, 255));
         a = AW'($urandom);
         send_word(a, p ^ s, p, 1'b0);
         cmp_vld_in = 1'b0;
         checks++;
         if (log_vld_out !== 1'b1 || {log_addr_out, log_syn_out} !== m_q[0]) begin
            errors++;
            $display("FAIL full_head_%0d: got %0h want %0h", i,
                     {log_addr_out, log_syn_out}, m_q[0]);
         end
         log_rd_in = 1'b1;
         tick();
         log_rd_in = 1'b0;
         void'(m_q.pop_front());
         m_q.push_back({a, s});
         m_cnt++;
      end
      check_results("full");
      drain_and_check("full");
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] p;
      start_session();
      for (int i = 0; i < 9; i++) begin
         if ($urandom_range(0, 1) != 0) send_miss(1'b1);
         else begin
            p = DW'($urandom);
            send_word(AW'($urandom), p, p, 1'b1);
         end
      end
      end_in = 1'b1;
      send_word(8'hE7, 8'h0F, 8'hF0, 1'b1);
      end_in = 1'b0;
      send_word(8'h99, 8'h01, 8'h02, 1'b0);
      cmp_vld_in = 1'b0;
      tick();
      checks++;
      if (done_out !== 1'b1) begin
         errors++;
         $display("FAIL b2b_done: got %0b want 1", done_out);
      end
      check_results("b2b");
      drain_and_check("b2b");
   endtask

   task automatic test_restart();
      start_session();
      for (int i = 0; i < 3; i++) send_miss(1'b1);
      cmp_vld_in = 1'b0;
      tick();
      tick();
      check_results("pre_restart");
      sbmt_in = 1'b1;
      send_miss(1'b0);
      sbmt_in = 1'b0;
      cmp_vld_in = 1'b0;
      model_clear();
      tick();
      tick();
      check_results("restart");
      checks++;
      if (busy_out !== 1'b1 || done_out !== 1'b0 || log_vld_out !== 1'b0) begin
         errors++;
         $display("FAIL restart_state: got busy=%0b done=%0b vld=%0b want 1 0 0",
                  busy_out, done_out, log_vld_out);
      end
   endtask

   task automatic test_saturation();
      start_session();
      for (int i = 0; i < 20; i++) send_miss(1'b1);
      cmp_vld_in = 1'b0;
      tick();
      tick();
      check_results("sat");
      send_miss(1'b0);
      cmp_vld_in = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if ({busy_out, done_out, fail_out, ovf_out, err_cnt_out, log_vld_out,
           log_addr_out, log_syn_out} !== '0) begin
         errors++;
         $display("FAIL async_reset: got busy=%0b fail=%0b ovf=%0b cnt=%0d vld=%0b want all 0",
                  busy_out, fail_out, ovf_out, err_cnt_out, log_vld_out);
      end
      tick();
      rst = 1'b1;
      tick();
      tick();
      checks++;
      if (busy_out !== 1'b0 || fail_out !== 1'b0 || err_cnt_out !== '0) begin
         errors++;
         $display("FAIL post_reset_idle: got busy=%0b fail=%0b cnt=%0d want 0 0 0",
                  busy_out, fail_out, err_cnt_out);
      end
   endtask

   initial begin
      model_clear();
      test_reset();
      test_clean();
      test_single_miss();
      test_overflow();
      test_push_pop_full();
      test_back_to_back();
      test_restart();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
